// File: rtl/regwrite_arbiter.sv
// Register-file write-port arbiter for ALU and memory writebacks.
// Also tracks pending writes per register for issue hazard checks.
module regwrite_arbiter #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [REG_W-1:0]      alu_reg,
  input  logic [DATA_W-1:0]     alu_data,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [REG_W-1:0]      mem_reg,
  input  logic [DATA_W-1:0]     mem_data,
  input  logic                  issue_valid,
  input  logic [REG_W-1:0]      issue_reg,
  output logic                  wr_en,
  output logic [REG_W-1:0]      wr_reg,
  output logic [DATA_W-1:0]     wr_data,
  output logic [(1<<REG_W)-1:0] busy,
  output logic                  sb_err
);

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } src_e;

  logic                  alu_full;
  logic [REG_W-1:0]      alu_breg;
  logic [DATA_W-1:0]     alu_bdata;
  logic                  mem_full;
  logic [REG_W-1:0]      mem_breg;
  logic [DATA_W-1:0]     mem_bdata;
  src_e                  rr_ptr;
  logic                  gnt_alu;
  logic                  gnt_mem;
  logic                  both;
  logic [(1<<REG_W)-1:0] busy_nxt;
  logic                  hazard;

  // Grant selection over full buffers; rr_ptr only breaks ties
  always_comb begin
    both    = alu_full && mem_full;
    gnt_alu = alu_full && (!mem_full || rr_ptr == SRC_ALU);
    gnt_mem = mem_full && (!alu_full || rr_ptr == SRC_MEM);
  end

  // Slot is free when empty or being drained this cycle
  always_comb begin
    alu_ready = !alu_full || gnt_alu;
    mem_ready = !mem_full || gnt_mem;
  end

  // Next scoreboard: clear the written reg, then a new allocation wins
  always_comb begin
    busy_nxt = busy;
    if (wr_en) busy_nxt[wr_reg] = 1'b0;
    if (issue_valid) busy_nxt[issue_reg] = 1'b1;
    hazard = issue_valid && busy[issue_reg] &&
             !(wr_en && wr_reg == issue_reg);
  end

  // ALU one-entry buffer: load beats pop when both happen
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_full  <= 1'b0;
      alu_breg  <= '0;
      alu_bdata <= '0;
    end else if (alu_valid && alu_ready) begin
      alu_full  <= 1'b1;
      alu_breg  <= alu_reg;
      alu_bdata <= alu_data;
    end else if (gnt_alu) begin
      alu_full  <= 1'b0;
    end
  end

  // Memory one-entry buffer: load beats pop when both happen
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_full  <= 1'b0;
      mem_breg  <= '0;
      mem_bdata <= '0;
    end else if (mem_valid && mem_ready) begin
      mem_full  <= 1'b1;
      mem_breg  <= mem_reg;
      mem_bdata <= mem_data;
    end else if (gnt_mem) begin
      mem_full  <= 1'b0;
    end
  end

  // Round-robin pointer moves only when both buffers contend
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= SRC_ALU;
    end else if (both) begin
      rr_ptr <= gnt_alu ? SRC_MEM : SRC_ALU;
    end
  end

  // Register the granted entry onto the write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en   <= 1'b0;
      wr_reg  <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= gnt_alu || gnt_mem;
      unique case (1'b1)
        gnt_alu: begin
          wr_reg  <= alu_breg;
          wr_data <= alu_bdata;
        end
        gnt_mem: begin
          wr_reg  <= mem_breg;
          wr_data <= mem_bdata;
        end
        default: ;
      endcase
    end
  end

  // Pending-write scoreboard and sticky double-allocation flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy   <= '0;
      sb_err <= 1'b0;
    end else begin
      busy <= busy_nxt;
      if (hazard) sb_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regwrite_arbiter.sv
// Self-checking bench for regwrite_arbiter.
// Expected writes queue up at drive time; a monitor pops them.
module tb_regwrite_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid;
  logic        alu_ready;
  logic [3:0]  alu_reg;
  logic [15:0] alu_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [3:0]  mem_reg;
  logic [15:0] mem_data;
  logic        issue_valid;
  logic [3:0]  issue_reg;
  logic        wr_en;
  logic [3:0]  wr_reg;
  logic [15:0] wr_data;
  logic [15:0] busy;
  logic        sb_err;

  regwrite_arbiter #(.DATA_W(16), .REG_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready),
    .alu_reg(alu_reg), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_reg(mem_reg), .mem_data(mem_data),
    .issue_valid(issue_valid), .issue_reg(issue_reg),
    .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data),
    .busy(busy), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  r;
    logic [15:0] d;
  } wr_t;

  typedef struct {
    bit          use_mem;
    logic [3:0]  rg;
    logic [15:0] dat;
    logic [3:0]  exp_reg;
    logic [15:0] exp_data;
  } vec_t;

  wr_t  expq[$];
  vec_t tbl[6];
  int   ntests = 0;
  int   nfail  = 0;
  int   wr_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] r, input logic [15:0] d);
    wr_t e;
    e.r = r;
    e.d = d;
    expq.push_back(e);
  endtask

  // Every write strobe must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n && wr_en) begin
      wr_cnt++;
      if (expq.size() == 0) begin
        ntests++;
        nfail++;
        $display("FAIL unexpected_write: got reg=%0d data=%h, required none",
                 wr_reg, wr_data);
      end else begin
        wr_t e;
        e = expq.pop_front();
        chk("mon_wr_reg", 32'(wr_reg), 32'(e.r));
        chk("mon_wr_data", 32'(wr_data), 32'(e.d));
      end
    end
  end

  initial begin
    int snap;
    tbl[0] = '{1'b1, 4'd0,  16'h0000, 4'd0,  16'h0000};
    tbl[1] = '{1'b0, 4'd15, 16'hFFFF, 4'd15, 16'hFFFF};
    tbl[2] = '{1'b0, 4'd10, 16'hA5A5, 4'd10, 16'hA5A5};
    tbl[3] = '{1'b1, 4'd15, 16'h1234, 4'd15, 16'h1234};
    tbl[4] = '{1'b1, 4'd8,  16'h8001, 4'd8,  16'h8001};
    tbl[5] = '{1'b0, 4'd0,  16'h7FFE, 4'd0,  16'h7FFE};

    rst_n = 1'b0;
    alu_valid = 1'b0; alu_reg = '0; alu_data = '0;
    mem_valid = 1'b0; mem_reg = '0; mem_data = '0;
    issue_valid = 1'b0; issue_reg = '0;

    #12;
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_reg", 32'(wr_reg), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sb_err", 32'(sb_err), 32'd0);
    chk("rst_alu_ready", 32'(alu_ready), 32'd1);
    chk("rst_mem_ready", 32'(mem_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // single ALU write
    tick();
    alu_valid = 1'b1; alu_reg = 4'd3; alu_data = 16'hBEEF;
    push(4'd3, 16'hBEEF);
    tick();
    alu_valid = 1'b0;
    chk("alu1_e1_wr_en", 32'(wr_en), 32'd0);
    tick();
    chk("alu1_e2_wr_en", 32'(wr_en), 32'd1);
    chk("alu1_e2_wr_reg", 32'(wr_reg), 32'd3);
    chk("alu1_e2_wr_data", 32'(wr_data), 32'hBEEF);
    tick();
    chk("alu1_e3_wr_en", 32'(wr_en), 32'd0);

    // back-to-back memory writes
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i >= 2) chk("b2b_wr_en", 32'(wr_en), 32'd1);
      mem_valid = 1'b1;
      mem_reg = 4'(4 + i);
      mem_data = 16'(16'h4000 + i);
      push(mem_reg, mem_data);
      #1;
      chk("b2b_mem_ready", 32'(mem_ready), 32'd1);
    end
    tick();
    mem_valid = 1'b0;
    chk("b2b_wr_en_a", 32'(wr_en), 32'd1);
    chk("b2b_wr_reg_a", 32'(wr_reg), 32'd6);
    tick();
    chk("b2b_wr_en_b", 32'(wr_en), 32'd1);
    chk("b2b_wr_reg_b", 32'(wr_reg), 32'd7);
    tick();
    chk("b2b_wr_en_end", 32'(wr_en), 32'd0);
    chk("b2b_q_empty", 32'(expq.size()), 32'd0);

    // table of isolated single-producer writes
    snap = wr_cnt;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (tbl[i].use_mem) begin
        mem_valid = 1'b1; mem_reg = tbl[i].rg; mem_data = tbl[i].dat;
      end else begin
        alu_valid = 1'b1; alu_reg = tbl[i].rg; alu_data = tbl[i].dat;
      end
      push(tbl[i].exp_reg, tbl[i].exp_data);
      tick();
      alu_valid = 1'b0;
      mem_valid = 1'b0;
      tick();
      chk("tbl_wr_en", 32'(wr_en), 32'd1);
      chk("tbl_wr_reg", 32'(wr_reg), 32'(tbl[i].exp_reg));
      chk("tbl_wr_data", 32'(wr_data), 32'(tbl[i].exp_data));
    end
    tick();
    chk("tbl_wr_count", 32'(wr_cnt - snap), 32'd6);
    chk("tbl_q_empty", 32'(expq.size()), 32'd0);

    // busy held until the edge after the write strobe
    tick();
    issue_valid = 1'b1; issue_reg = 4'd5;
    tick();
    issue_valid = 1'b0;
    chk("sb1_busy5_set", 32'(busy[5]), 32'd1);
    alu_valid = 1'b1; alu_reg = 4'd5; alu_data = 16'h5555;
    push(4'd5, 16'h5555);
    tick();
    alu_valid = 1'b0;
    chk("sb1_busy5_e1", 32'(busy[5]), 32'd1);
    tick();
    chk("sb1_wr_en", 32'(wr_en), 32'd1);
    chk("sb1_busy5_e2", 32'(busy[5]), 32'd1);
    tick();
    chk("sb1_busy5_clr", 32'(busy[5]), 32'd0);

    // allocation in the same cycle as the clearing write
    tick();
    issue_valid = 1'b1; issue_reg = 4'd5;
    tick();
    issue_valid = 1'b0;
    alu_valid = 1'b1; alu_reg = 4'd5; alu_data = 16'h0505;
    push(4'd5, 16'h0505);
    tick();
    alu_valid = 1'b0;
    tick();
    chk("sb2_wr_en", 32'(wr_en), 32'd1);
    issue_valid = 1'b1; issue_reg = 4'd5;
    tick();
    issue_valid = 1'b0;
    chk("sb2_busy5", 32'(busy[5]), 32'd1);
    chk("sb2_sb_err", 32'(sb_err), 32'd0);

    // double allocation without an intervening write
    tick();
    issue_valid = 1'b1; issue_reg = 4'd9;
    tick();
    chk("hz_first_err", 32'(sb_err), 32'd0);
    chk("hz_busy9", 32'(busy[9]), 32'd1);
    tick();
    issue_valid = 1'b0;
    chk("hz_second_err", 32'(sb_err), 32'd1);
    tick();
    tick();
    chk("hz_sticky", 32'(sb_err), 32'd1);

    // two-way contention, then reset with both buffers full
    tick();
    alu_valid = 1'b1; alu_reg = 4'd1; alu_data = 16'h0011;
    mem_valid = 1'b1; mem_reg = 4'd2; mem_data = 16'h0022;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("ct_alu_ready", 32'(alu_ready), 32'(k % 2));
      chk("ct_mem_ready", 32'(mem_ready), 32'(1 - k % 2));
      if (k >= 2) begin
        chk("ct_wr_en", 32'(wr_en), 32'd1);
        chk("ct_wr_reg", 32'(wr_reg), (k % 2 == 0) ? 32'd1 : 32'd2);
      end
      if (k <= 6) begin
        if (k % 2 == 1) push(4'd1, 16'h0011);
        else push(4'd2, 16'h0022);
      end
      if (k == 3) begin
        issue_valid = 1'b1; issue_reg = 4'd12;
      end
      if (k == 4) issue_valid = 1'b0;
    end
    chk("ct_pre_sb_err", 32'(sb_err), 32'd1);
    chk("ct_pre_busy12", 32'(busy[12]), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mrst_wr_en", 32'(wr_en), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_sb_err", 32'(sb_err), 32'd0);
    chk("mrst_alu_ready", 32'(alu_ready), 32'd1);
    chk("mrst_mem_ready", 32'(mem_ready), 32'd1);
    chk("mrst_q_empty", 32'(expq.size()), 32'd0);
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    snap = wr_cnt;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) tick();
    chk("mrst_no_stale", 32'(wr_cnt - snap), 32'd0);
    chk("mrst_wr_en_after", 32'(wr_en), 32'd0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
